pwm_multi_core: RTL and testbench

Parameterised multi-channel PWM generator. Successor to the single-channel percent-duty PWM core.
- N_CH channels share one programmable period counter.
- Per-channel duty is given in clk ticks.
- Edge-aligned or centred mode is selectable at run time.
- Double-buffered (shadow) configuration is applied glitch-free at period boundaries.
- Sits between the register/UART command layer and the output pins.

---
 rtl/pwm_multi_core.sv | 171 +++++++++++++++++
 tb/tb_pwm_multi_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_core.sv
// ---------------------------------------------------------------------------
// pwm_multi_core
//
// Multi-channel PWM generator. All N_CH channels share one programmable
// period counter. Each channel has its own duty (in clk ticks). Edge-aligned
// or centred output is selectable at run time. New configuration is captured
// into a shadow register set and moved to the active set only at a period
// boundary (or at once while idle), so an output never glitches mid-period.
//
// Optional feature: define PWM_POLARITY_EN to add a per-channel output
// polarity (pol_in). The polarity travels through the shadow with the rest of
// the configuration and also sets each channel's idle level.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           run enable; 0 holds the counter at 0 with outputs idle
//   cfg_load     one-cycle strobe capturing period_in/duty_in/mode_in
//   period_in    requested period in ticks (must be >= 2)
//   duty_in      packed per-channel duty, channel i at [i*CNT_W +: CNT_W]
//   mode_in      0 = edge-aligned, 1 = centred
//   pol_in       (PWM_POLARITY_EN only) per-channel output inversion
//   pwm_out      registered PWM outputs, aligned with count_out
//   count_out    current counter value
//   period_tick  one-cycle pulse in the cycle the counter shows 0 after a wrap
//   pending      shadow holds configuration not yet applied
//   cfg_err      one-cycle pulse: cfg_load rejected (period_in < 2)
// ---------------------------------------------------------------------------
module pwm_multi_core #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cfg_load,
  input  logic [CNT_W-1:0]       period_in,
  input  logic [N_CH*CNT_W-1:0]  duty_in,
  input  logic                   mode_in,
`ifdef PWM_POLARITY_EN
  input  logic [N_CH-1:0]        pol_in,
`endif
  output logic [N_CH-1:0]        pwm_out,
  output logic [CNT_W-1:0]       count_out,
  output logic                   period_tick,
  output logic                   pending,
  output logic                   cfg_err
);

  typedef enum logic {
    MODE_EDGE    = 1'b0,
    MODE_CENTRED = 1'b1
  } mode_t;

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      act_period, sh_period;
  logic [N_CH*CNT_W-1:0] act_duty,   sh_duty;
  mode_t                 act_mode,   sh_mode;

  logic                  wrap;
  logic                  transfer;
  logic                  load_ok;
  logic [CNT_W-1:0]      count_nxt;
  logic [CNT_W-1:0]      nxt_period;
  logic [N_CH*CNT_W-1:0] nxt_duty;
  mode_t                 nxt_mode;
  logic [N_CH-1:0]       nxt_pol;
  logic [N_CH-1:0]       raw;
  logic [N_CH-1:0]       pwm_nxt;

`ifdef PWM_POLARITY_EN
  logic [N_CH-1:0]       act_pol, sh_pol;
`endif

  assign wrap      = en && (count == act_period - CNT_W'(1));
  assign load_ok   = cfg_load && (period_in >= CNT_W'(2));
  // While idle a pending config is applied straight away; while running
  // only at the wrap, so the new values govern count 0 onward.
  assign transfer  = pending && (!en || wrap);
  assign count_nxt = (!en || wrap) ? '0 : count + CNT_W'(1);

  // The output register is computed from the next count and the config that
  // will be active for it, which keeps pwm_out aligned with count_out.
  assign nxt_period = transfer ? sh_period : act_period;
  assign nxt_duty   = transfer ? sh_duty   : act_duty;
  assign nxt_mode   = transfer ? sh_mode   : act_mode;

`ifdef PWM_POLARITY_EN
  assign nxt_pol    = transfer ? sh_pol : act_pol;
`else
  assign nxt_pol    = '0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_i;
    logic [CNT_W-1:0] d_eff;
    logic [CNT_W-1:0] s_off;

    assign duty_i = nxt_duty[i*CNT_W +: CNT_W];
    // Clamping to P makes D>=P a solid 1 across the wrap.
    assign d_eff  = (duty_i > nxt_period) ? nxt_period : duty_i;
    // d_eff <= P, so neither the subtraction nor s_off + d_eff overflows.
    assign s_off  = (nxt_period - d_eff) >> 1;
    assign raw[i] = (nxt_mode == MODE_CENTRED)
                    ? ((count_nxt >= s_off) && (count_nxt < s_off + d_eff))
                    : (count_nxt < d_eff);
  end

  assign pwm_nxt = en ? (raw ^ nxt_pol) : nxt_pol;

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      count       <= count_nxt;
      pwm_out     <= pwm_nxt;
      period_tick <= wrap;
      cfg_err     <= cfg_load && !load_ok;
    end
  end

  // Active config is updated before the shadow is overwritten, so a load
  // that coincides with a wrap leaves the older pending config to transfer
  // now and the new one pending until the following wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_period <= RST_P;
      act_duty   <= '0;
      act_mode   <= MODE_EDGE;
      sh_period  <= RST_P;
      sh_duty    <= '0;
      sh_mode    <= MODE_EDGE;
      pending    <= 1'b0;
    end else begin
      if (transfer) begin
        act_period <= sh_period;
        act_duty   <= sh_duty;
        act_mode   <= sh_mode;
      end
      if (load_ok) begin
        sh_period <= period_in;
        sh_duty   <= duty_in;
        sh_mode   <= mode_t'(mode_in);
        pending   <= 1'b1;
      end else if (transfer) begin
        pending   <= 1'b0;
      end
    end
  end

`ifdef PWM_POLARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      act_pol <= '0;
      sh_pol  <= '0;
    end else begin
      if (transfer) act_pol <= sh_pol;
      if (load_ok)  sh_pol  <= pol_in;
    end
  end
`endif

  assign count_out = count;

endmodule

// File: tb/tb_pwm_multi_core.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_core
//
// Self-checking bench for pwm_multi_core (default parameters). Each directed
// step drives the inputs, advances a small behavioural reference of the
// block, pushes the expected post-edge outputs to a scoreboard queue, then
// clocks the DUT and pops/compares the outputs one cycle later.
// ---------------------------------------------------------------------------
module tb_pwm_multi_core;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 16;
  localparam int RST_PERIOD = 1000;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  cfg_load;
  logic [CNT_W-1:0]      period_in;
  logic [N_CH*CNT_W-1:0] duty_in;
  logic                  mode_in;
  logic [N_CH-1:0]       pwm_out;
  logic [CNT_W-1:0]      count_out;
  logic                  period_tick;
  logic                  pending;
  logic                  cfg_err;
`ifdef PWM_POLARITY_EN
  logic [N_CH-1:0]       pol_in;
`endif

  pwm_multi_core #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .RST_PERIOD (RST_PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_load    (cfg_load),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .mode_in     (mode_in),
`ifdef PWM_POLARITY_EN
    .pol_in      (pol_in),
`endif
    .pwm_out     (pwm_out),
    .count_out   (count_out),
    .period_tick (period_tick),
    .pending     (pending),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  pwm;
    logic             tick;
    logic             pend;
    logic             err;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: active and shadow config, counter, pending flag
  int m_cnt, m_p, m_mode, m_sp, m_smode;
  int m_d[N_CH];
  int m_sd[N_CH];
  bit m_pend;
  bit cur_en;

  function automatic logic [N_CH-1:0] model_pwm(input int c);
    logic [N_CH-1:0] r;
    int d, s;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      d = (m_d[i] < m_p) ? m_d[i] : m_p;
      if (m_mode == 0) begin
        r[i] = (c < d);
      end else begin
        s = (m_p - d) / 2;
        r[i] = (c >= s) && (c < s + d);
      end
    end
    return r;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("[TB] FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    assert (count_out === e.cnt) else begin
      n_bad++;
      $error("[TB] FAIL count_out got %0d want %0d", count_out, e.cnt);
    end
    n_cmp++;
    assert (pwm_out === e.pwm) else begin
      n_bad++;
      $error("[TB] FAIL pwm_out at count %0d got %b want %b", e.cnt, pwm_out, e.pwm);
    end
    n_cmp++;
    assert (period_tick === e.tick) else begin
      n_bad++;
      $error("[TB] FAIL period_tick at count %0d got %b want %b", e.cnt, period_tick, e.tick);
    end
    n_cmp++;
    assert (pending === e.pend) else begin
      n_bad++;
      $error("[TB] FAIL pending at count %0d got %b want %b", e.cnt, pending, e.pend);
    end
    n_cmp++;
    assert (cfg_err === e.err) else begin
      n_bad++;
      $error("[TB] FAIL cfg_err at count %0d got %b want %b", e.cnt, cfg_err, e.err);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e_in, input bit ld, input int p,
                               input int d0, input int d1, input int d2, input int d3,
                               input bit md);
    exp_t e;
    bit   wrap;
    int   dv[N_CH];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;

    rst       = r;
    en        = e_in;
    cfg_load  = ld;
    period_in = CNT_W'(p);
    duty_in   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    mode_in   = md;

    e.tick = 1'b0;
    e.err  = 1'b0;
    if (r) begin
      m_cnt = 0; m_p = RST_PERIOD; m_mode = 0;
      m_sp = RST_PERIOD; m_smode = 0; m_pend = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_d[i] = 0;
        m_sd[i] = 0;
      end
      e.pwm = '0;
    end else begin
      wrap   = e_in && (m_cnt == m_p - 1);
      e.tick = wrap;
      m_cnt  = (!e_in || wrap) ? 0 : m_cnt + 1;
      if (m_pend && (!e_in || wrap)) begin
        m_p = m_sp; m_mode = m_smode; m_pend = 1'b0;
        for (int i = 0; i < N_CH; i++) m_d[i] = m_sd[i];
      end
      if (ld) begin
        if (p >= 2) begin
          m_sp = p; m_smode = md; m_pend = 1'b1;
          for (int i = 0; i < N_CH; i++) m_sd[i] = dv[i];
        end else begin
          e.err = 1'b1;
        end
      end
      e.pwm = e_in ? model_pwm(m_cnt) : '0;
    end
    e.cnt  = CNT_W'(m_cnt);
    e.pend = m_pend;
    sb.push_back(e);

    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic step_idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, cur_en, 1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic load_cfg(input int p, input int d0, input int d1, input int d2,
                          input int d3, input bit md);
    applyStimulus(1'b0, cur_en, 1'b1, p, d0, d1, d2, d3, md);
  endtask

  task automatic run_to(input int target);
    for (int g = 0; g < 2000 && m_cnt != target; g++) step_idle(1);
  endtask

  initial begin
`ifdef PWM_POLARITY_EN
    pol_in    = '0;
`endif
    rst       = 1'b1;
    en        = 1'b0;
    cfg_load  = 1'b0;
    period_in = '0;
    duty_in   = '0;
    mode_in   = 1'b0;
    cur_en    = 1'b0;
    m_cnt = 0; m_p = RST_PERIOD; m_mode = 0; m_sp = RST_PERIOD; m_smode = 0;
    m_pend = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_d[i] = 0;
      m_sd[i] = 0;
    end
    $display("[TB] start pwm_multi_core bench");

    // reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    step_idle(1);

    // idle load: pending for one cycle, then applied
    load_cfg(10, 0, 3, 10, 15, 1'b0);
    step_idle(1);

    // edge mode, duties 0/3/10/15 at P=10; no tick on en rise
    cur_en = 1'b1;
    step_idle(25);

    // grow period to 20 mid-period; old config holds until wrap
    run_to(4);
    load_cfg(20, 0, 3, 10, 15, 1'b0);
    step_idle(30);

    // rejected load
    load_cfg(1, 5, 5, 5, 5, 1'b1);
    step_idle(3);

    // centred, P=10, ch0 duty 4 -> counts 3..6
    load_cfg(10, 4, 0, 10, 7, 1'b1);
    step_idle(45);

    // centred, P=9, ch0 duty 4 -> counts 2..5
    load_cfg(9, 4, 2, 9, 1, 1'b1);
    step_idle(25);

    // load coinciding with wrap while an earlier load is pending
    run_to(5);
    load_cfg(12, 1, 2, 3, 4, 1'b0);
    run_to(8);
    load_cfg(6, 6, 3, 2, 0, 1'b1);
    step_idle(30);

    // two loads in one period: last wins
    run_to(1);
    load_cfg(8, 1, 1, 1, 1, 1'b0);
    step_idle(1);
    load_cfg(7, 2, 0, 7, 3, 1'b1);
    step_idle(20);

    // en falling with a pending config
    run_to(3);
    cur_en = 1'b0;
    load_cfg(10, 5, 0, 0, 10, 1'b0);
    step_idle(3);
    cur_en = 1'b1;
    step_idle(15);

    // reset mid-period with pending config, then run a full reset period
    run_to(5);
    load_cfg(16, 8, 8, 8, 8, 1'b0);
    step_idle(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    step_idle(RST_PERIOD + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
